// File: rtl/pixel_streamer.sv
// pixel_streamer: reads a run of result-RAM words and streams one 8-bit pixel
// per word over a valid/ready interface, with m_last on the final pixel.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | issuing reads while the 2-entry FIFO plus in-flight read has room
// DRAIN | all reads issued; waiting for the m_last beat to be accepted
//
// The read port has a fixed 1-cycle latency. A read issued in cycle t is pushed
// into the FIFO at the end of cycle t+1, so each cycle we count the FIFO entries,
// the read still in flight, and the pop happening now. A read is issued only when
// that total is below 2, so the FIFO can never overflow and no pixel is dropped.
module pixel_streamer #(
  parameter int ADDR_W  = 18,
  parameter int PIX_LSB = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] pix_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] issue_idx;
  logic [ADDR_W-1:0] ret_idx;
  logic              inflight;

  logic [7:0]        fifo_pix  [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              pop;
  logic              push;
  logic              push_last;
  logic              issue;
  logic [2:0]        occupancy;

  assign m_valid   = (fifo_count != 2'd0);
  assign m_data    = fifo_pix[rd_ptr];
  assign m_last    = m_valid & fifo_last[rd_ptr];
  assign busy      = (state != IDLE);
  assign pop       = m_valid & m_ready;
  assign push      = inflight;
  assign push_last = (ret_idx == count_q - ONE);

  // pop implies fifo_count >= 1, so this never underflows
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && (issue_idx < count_q) && (occupancy < 3'd2);

  // Sequencing FSM, read issue, return counter and FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issue_idx  <= '0;
      ret_idx    <= '0;
      mem_addr   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pix_count != '0) begin
              base_q    <= base_addr;
              count_q   <= pix_count;
              issue_idx <= '0;
              ret_idx   <= '0;
              mem_addr  <= base_addr;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issue_idx <= issue_idx + ONE;
            mem_addr  <= base_q + issue_idx + ONE;
          end
          if (issue_idx == count_q) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      inflight <= issue;
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        ret_idx <= ret_idx + ONE;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while fifo_count is 0, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pix[wr_ptr]  <= mem_rdata[PIX_LSB +: 8];
      fifo_last[wr_ptr] <= push_last;
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: frames push expected {last,pixel} into a
// queue; a negedge monitor pops and compares every accepted beat.
module tb_pixel_streamer;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] pix_count = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [7:0]        m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  pixel_streamer #(.ADDR_W(ADDR_W), .PIX_LSB(0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .pix_count(pix_count), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int beats = 0;
  int last_beat_cyc = -100;
  int ready_mode = 0;
  logic [8:0] exp_q[$];

  function automatic logic [7:0] pix_of(input logic [ADDR_W-1:0] a);
    return a[7:0] + 8'h90;
  endfunction

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'h5A, 16'hC3C3, pix_of(a)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM model: address seen in cycle c returns data in cycle c+1
  initial begin
    logic [ADDR_W-1:0] addr_s;
    addr_s = '0;
    forever begin
      @(negedge clk);
      addr_s = mem_addr;
      @(posedge clk);
      #1;
      mem_rdata = word_of(addr_s);
    end
  end

  // Sink ready: always 1, or the repeating pattern 1,0,0
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) m_ready = 1'b1;
      else m_ready = (phase == 0);
      phase = (phase + 1) % 3;
    end
  end

  // Monitor: compares accepted beats and checks hold-during-stall
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (!(m_valid && m_data == prev_data && m_last == prev_last)) begin
            fails++;
            $display("FAIL stall_hold: got v=%0b d=%h l=%0b, need v=1 d=%h l=%0b",
                     m_valid, m_data, m_last, prev_data, prev_last);
          end
        end
        if (m_valid && m_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got d=%h l=%0b, need no beat", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if ({m_last, m_data} !== e) begin
              fails++;
              $display("FAIL beat_data: got l=%0b d=%h, need l=%0b d=%h",
                       m_last, m_data, e[8], e[7:0]);
            end
          end
          beats++;
          if (m_last) last_beat_cyc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  // Queue the expected pixels and present start for one sampling edge
  task automatic start_frame(input logic [ADDR_W-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      logic [ADDR_W-1:0] a;
      a = b + ADDR_W'(k);
      exp_q.push_back({(k == n - 1), pix_of(a)});
    end
    start     = 1'b1;
    base_addr = b;
    pix_count = ADDR_W'(n);
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: got no done, need done within 300 cycles", name);
    end else begin
      check({name, "_done_after_last"}, cyc, last_beat_cyc + 1);
      check({name, "_queue_empty"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    int c0;
    int b0;
    int n;

    // reset state
    #2;
    check("reset_flags", {m_valid, m_last, busy, done}, 4'b0000);
    check("reset_addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // four pixels at full rate, with first-valid latency
    start_frame(18'h00010, 4);
    c0 = cyc;
    check("busy_after_start", busy, 1);
    tick();
    check("valid_lat_1", m_valid, 0);
    tick();
    check("valid_lat_2", m_valid, 1);
    wait_done("basic");
    check("basic_full_rate", cyc - c0, 6);
    tick();
    check("basic_done_pulse", {done, busy}, 2'b00);

    // address wrap
    start_frame(18'h3FFFE, 4);
    check("wrap_addr0", mem_addr, 18'h3FFFE);
    tick();
    check("wrap_addr1", mem_addr, 18'h3FFFF);
    tick();
    check("wrap_addr2", mem_addr, 18'h00000);
    tick();
    check("wrap_addr3", mem_addr, 18'h00001);
    wait_done("wrap");

    // backpressure
    ready_mode = 1;
    start_frame(18'h00020, 8);
    wait_done("stall");
    ready_mode = 0;
    tick();

    // zero-length frame
    start = 1'b1;
    pix_count = '0;
    base_addr = 18'h00055;
    tick();
    start = 1'b0;
    check("zero_done", {done, busy, m_valid}, 3'b100);
    tick();
    check("zero_after", {done, busy, m_valid}, 3'b000);
    tick();

    // start while busy is ignored
    start_frame(18'h00040, 5);
    tick();
    start = 1'b1;
    base_addr = 18'h00100;
    pix_count = 18'd3;
    tick();
    tick();
    start = 1'b0;
    wait_done("busy_start");
    for (int i = 0; i < 6; i++) tick();
    check("busy_start_idle", {busy, m_valid}, 2'b00);

    // reset mid-frame, then a fresh frame
    b0 = beats;
    start_frame(18'h00080, 10);
    n = 0;
    while (beats < b0 + 3 && n < 100) begin
      tick();
      n++;
    end
    check("mid_three_beats", beats - b0, 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {m_valid, m_last, busy, done}, 4'b0000);
    check("mid_rst_addr", mem_addr, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("mid_no_beats", beats - b0, 3);
    check("mid_idle", {busy, m_valid}, 2'b00);
    start_frame(18'h00090, 2);
    wait_done("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
